// File: rtl/subtb_quan_seq.sv
// Encoder log-domain quantizer: |D| -> log2, subtract Y>>2, serial search of the rate table for ADPCM code I.
// One sample in flight; accepts only in IDLE, result held in DONE until out_ready.

module subtb_quan_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] D,
  input  logic [12:0] Y,
  input  logic [1:0]  rate,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  I,
  output logic [11:0] DLN
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOG  = 3'd1,
    S_SUB  = 3'd2,
    S_SRCH = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [15:0] d_q;
  logic [12:0] y_q;
  logic [1:0]  rate_q;
  logic [10:0] dl_q;
  logic [11:0] dln_q;
  logic [3:0]  k_q;
  logic [3:0]  m_q;
  logic [4:0]  i_q;
  logic [11:0] dln_out_q;

  function automatic logic [3:0] tbl_len(input logic [1:0] r);
    case (r)
      2'b11:   tbl_len = 4'd1;
      2'b10:   tbl_len = 4'd3;
      2'b01:   tbl_len = 4'd7;
      default: tbl_len = 4'd15;
    endcase
  endfunction

  function automatic logic signed [11:0] thr(input logic [1:0] r, input logic [3:0] k);
    thr = '0;
    case (r)
      2'b11: thr = 12'sd261;
      2'b10: begin
        case (k)
          4'd0:    thr = 12'sd8;
          4'd1:    thr = 12'sd218;
          default: thr = 12'sd331;
        endcase
      end
      2'b01: begin
        case (k)
          4'd0:    thr = -12'sd124;
          4'd1:    thr = 12'sd80;
          4'd2:    thr = 12'sd178;
          4'd3:    thr = 12'sd246;
          4'd4:    thr = 12'sd300;
          4'd5:    thr = 12'sd349;
          default: thr = 12'sd400;
        endcase
      end
      default: begin
        case (k)
          4'd0:    thr = -12'sd122;
          4'd1:    thr = -12'sd16;
          4'd2:    thr = 12'sd68;
          4'd3:    thr = 12'sd139;
          4'd4:    thr = 12'sd198;
          4'd5:    thr = 12'sd250;
          4'd6:    thr = 12'sd298;
          4'd7:    thr = 12'sd339;
          4'd8:    thr = 12'sd378;
          4'd9:    thr = 12'sd413;
          4'd10:   thr = 12'sd445;
          4'd11:   thr = 12'sd475;
          4'd12:   thr = 12'sd502;
          4'd13:   thr = 12'sd528;
          default: thr = 12'sd553;
        endcase
      end
    endcase
  endfunction

  // 16k uses its own 2-bit mapping; the other rates fold sign around 2N+1.
  function automatic logic [4:0] code_map(input logic [1:0] r, input logic ds, input logic [3:0] m);
    logic [4:0] top;
    top = {tbl_len(r), 1'b1};
    if (r == 2'b11)
      code_map = ds ? (5'd1 - {4'd0, m[0]}) : (5'd2 + {4'd0, m[0]});
    else if (ds)
      code_map = top - {1'b0, m};
    else if (m == 4'd0)
      code_map = top;
    else
      code_map = {1'b0, m};
  endfunction

  logic [14:0]        dqm;
  logic [3:0]         expo;
  logic [6:0]         mant;
  logic [10:0]        dl_c;
  logic [11:0]        dln_c;
  logic signed [11:0] thr_k;
  logic               ge;
  logic               done_now;
  logic [3:0]         k_inc;
  logic [3:0]         m_nxt;
  logic [4:0]         code_c;

  always_comb begin
    dqm = d_q[14:0];
    if (d_q[15])
      dqm = (d_q == 16'h8000) ? 15'h7FFF : 15'(~d_q + 16'd1);
    expo = '0;
    for (int b = 1; b < 15; b++)
      if (dqm[b]) expo = 4'(b);
    mant     = 7'({dqm, 7'b0} >> expo);
    dl_c     = {expo, mant};
    dln_c    = 12'({2'b00, dl_q} - (y_q >> 2));
    thr_k    = thr(rate_q, k_q);
    ge       = $signed(dln_q) >= thr_k;
    k_inc    = k_q + 4'd1;
    m_nxt    = ge ? k_inc : m_q;
    done_now = !ge || (k_inc >= tbl_len(rate_q));
    code_c   = code_map(rate_q, d_q[15], m_nxt);
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_LOG;
      S_LOG:   state_nxt = S_SUB;
      S_SUB:   state_nxt = S_SRCH;
      S_SRCH:  if (done_now) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      d_q       <= '0;
      y_q       <= '0;
      rate_q    <= '0;
      dl_q      <= '0;
      dln_q     <= '0;
      k_q       <= '0;
      m_q       <= '0;
      i_q       <= '0;
      dln_out_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            d_q    <= D;
            y_q    <= Y;
            rate_q <= rate;
          end
        end
        S_LOG: dl_q <= dl_c;
        S_SUB: begin
          dln_q <= dln_c;
          k_q   <= '0;
          m_q   <= '0;
        end
        S_SRCH: begin
          k_q <= k_inc;
          m_q <= m_nxt;
          if (done_now) begin
            i_q       <= code_c;
            dln_out_q <= dln_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign I         = i_q;
  assign DLN       = dln_out_q;

endmodule

// File: tb/tb_subtb_quan_seq.sv
// Randomized bench for subtb_quan_seq with an arithmetic reference model and a per-cycle compare process.

module tb_subtb_quan_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] D;
  logic [12:0] Y;
  logic [1:0]  rate;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  I;
  logic [11:0] DLN;

  always #5 clk = ~clk;

  subtb_quan_seq dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .D        (D),
    .Y        (Y),
    .rate     (rate),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .I        (I),
    .DLN      (DLN)
  );

  int checks = 0;
  int errors = 0;

  int t16[1]  = '{261};
  int t24[3]  = '{8, 218, 331};
  int t32[7]  = '{-124, 80, 178, 246, 300, 349, 400};
  int t40[15] = '{-122, -16, 68, 139, 198, 250, 298, 339, 378, 413, 445, 475, 502, 528, 553};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: code = mapping of how many thresholds DLN reaches; latency = 3 + compares made.
  task automatic model(input logic [15:0] d, input logic [12:0] y, input logic [1:0] r,
                       output int code, output int dln, output int lat);
    int mag, e, mant, dl, sdln, n, m, th;
    mag = d[15] ? ((d == 16'h8000) ? 32767 : 65536 - int'(d)) : int'(d);
    e = 0;
    for (int b = 0; b < 15; b++) if (mag >= (1 << b)) e = b;
    mant = ((mag << 7) >> e) & 127;
    dl   = e * 128 + mant;
    dln  = (dl + 4096 - int'(y) / 4) % 4096;
    sdln = (dln >= 2048) ? dln - 4096 : dln;
    case (r)
      2'b11:   n = 1;
      2'b10:   n = 3;
      2'b01:   n = 7;
      default: n = 15;
    endcase
    m = 0;
    for (int k = 0; k < n; k++) begin
      case (r)
        2'b11:   th = t16[0];
        2'b10:   th = t24[k];
        2'b01:   th = t32[k];
        default: th = t40[k];
      endcase
      if (sdln >= th) m++;
    end
    lat = 3 + ((m + 1 < n) ? m + 1 : n);
    if (r == 2'b11)  code = d[15] ? 1 - m : 2 + m;
    else if (d[15])  code = 2 * n + 1 - m;
    else if (m == 0) code = 2 * n + 1;
    else             code = m;
  endtask

  // Compare process state
  int cyc = 0;
  bit busy = 1'b0;
  int acc_cyc = 0;
  int e_code = 0, e_dln = 0, e_lat = 0;
  int last_i = 0, last_dln = 0;
  int rdy_mode = 1;

  always @(negedge clk) begin
    bit idle, exp_valid;
    cyc++;
    if (!reset_n) begin
      busy     = 1'b0;
      last_i   = 0;
      last_dln = 0;
    end else begin
      idle      = !busy;
      exp_valid = busy && (cyc - acc_cyc >= e_lat);
      chk("in_ready", 32'(in_ready), 32'(idle));
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("I", 32'(I), e_code);
        chk("DLN", 32'(DLN), e_dln);
        if (out_ready) begin
          busy     = 1'b0;
          last_i   = e_code;
          last_dln = e_dln;
        end
      end else begin
        chk("I_hold", 32'(I), last_i);
        chk("DLN_hold", 32'(DLN), last_dln);
      end
      if (idle && in_valid) begin
        model(D, Y, rate, e_code, e_dln, e_lat);
        busy    = 1'b1;
        acc_cyc = cyc;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = ($urandom_range(0, 2) == 0);
      1:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  task automatic send(input logic [15:0] d, input logic [12:0] y, input logic [1:0] r);
    bit acc = 1'b0;
    int n = 0;
    D = d; Y = y; rate = r; in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      n++;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    D = 16'($urandom); Y = 13'($urandom); rate = 2'($urandom);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (busy && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input int max_cyc);
    int n = 0;
    while (!out_valid && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int c, dl, l;
    logic [15:0] d;
    logic [12:0] y;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    D = '0; Y = '0; rate = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Hand-computed anchors for the model itself
    model(16'h0000, 13'h0000, 2'b01, c, dl, l);
    chk("pin_zero_I", c, 1); chk("pin_zero_DLN", dl, 0); chk("pin_zero_lat", l, 5);
    model(16'hFFFF, 13'h0000, 2'b01, c, dl, l);
    chk("pin_neg1_I", c, 14);
    model(16'h0001, 13'h0800, 2'b01, c, dl, l);
    chk("pin_wrap_DLN", dl, 32'hE00); chk("pin_wrap_I", c, 15);
    model(16'h0400, 13'h0000, 2'b01, c, dl, l);
    chk("pin_400_DLN", dl, 32'h500); chk("pin_400_I", c, 7); chk("pin_400_lat", l, 10);
    model(16'h0400, 13'h1000, 2'b01, c, dl, l);
    chk("pin_400y_DLN", dl, 32'h100); chk("pin_400y_I", c, 4);
    model(16'h7FFF, 13'h0000, 2'b00, c, dl, l);
    chk("pin_max40_DLN", dl, 32'h77F); chk("pin_max40_I", c, 15); chk("pin_max40_lat", l, 18);
    model(16'h7FFF, 13'h0000, 2'b11, c, dl, l);
    chk("pin_max16_I", c, 3);
    model(16'hFFFF, 13'h0000, 2'b10, c, dl, l);
    chk("pin_neg24_I", c, 7);
    model(16'h8000, 13'h0000, 2'b01, c, dl, l);
    chk("pin_min32_I", c, 8);

    // Directed samples through the DUT
    rdy_mode = 1;
    send(16'h0000, 13'h0000, 2'b01); wait_idle(40);
    send(16'hFFFF, 13'h0000, 2'b01); wait_idle(40);
    send(16'h0001, 13'h0800, 2'b01); wait_idle(40);
    send(16'h0400, 13'h0000, 2'b01); wait_idle(40);
    send(16'h0400, 13'h1000, 2'b01); wait_idle(40);
    send(16'h7FFF, 13'h0000, 2'b00); wait_idle(40);
    send(16'h7FFF, 13'h0000, 2'b11); wait_idle(40);
    send(16'hFFFF, 13'h0000, 2'b10); wait_idle(40);
    send(16'h8000, 13'h0000, 2'b01); wait_idle(40);
    send(16'h8000, 13'h1FFF, 2'b00); wait_idle(40);

    // Backpressure: hold result 20 cycles, then exactly one transfer
    rdy_mode = 2;
    send(16'h0400, 13'h0000, 2'b01);
    wait_valid(40);
    repeat (20) @(posedge clk);
    #1 rdy_mode = 1;
    wait_idle(40);

    // Back-to-back: next sample offered while the previous one retires
    send(16'h1234, 13'h0100, 2'b00);
    send(16'hF00F, 13'h0040, 2'b10);
    wait_idle(40);

    // Reset during search
    send(16'h7FFF, 13'h0000, 2'b00);
    repeat (4) @(posedge clk);
    #1 pulse_reset();
    send(16'h0400, 13'h1000, 2'b01); wait_idle(40);

    // Reset while result is held
    rdy_mode = 2;
    send(16'h0001, 13'h0800, 2'b01);
    wait_valid(40);
    repeat (3) @(posedge clk);
    #1 pulse_reset();
    rdy_mode = 1;
    send(16'hFFFF, 13'h0000, 2'b01); wait_idle(40);

    // Randomized traffic with random downstream stalls
    rdy_mode = 0;
    for (int s = 0; s < 120; s++) begin
      d = 16'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) d = 16'(-d);
      if ($urandom_range(0, 15) == 0) d = 16'h8000;
      y = ($urandom_range(0, 1) == 1) ? 13'($urandom_range(0, 8191)) : 13'($urandom_range(0, 2047));
      send(d, y, 2'($urandom_range(0, 3)));
    end
    rdy_mode = 1;
    wait_idle(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
